// File: rtl/dcache_pkg.sv
// Shared geometry, address-field layout and FSM encoding for the direct-mapped data cache.
package dcache_pkg;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int LINE_W   = 128;
    localparam int TAG_W    = 26;
    localparam int IDX_W    = 2;
    localparam int WORD_W   = 2;
    localparam int CNT_W    = 32;

    // Byte address layout: [1:0] byte (ignored), [3:2] word, [5:4] index, [31:6] tag.
    localparam int WORD_LSB = 2;
    localparam int IDX_LSB  = WORD_LSB + WORD_W;
    localparam int TAG_LSB  = IDX_LSB + IDX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2,
        RESPOND   = 2'd3
    } state_t;

    // Line-aligned memory address built from a tag and an index; offset bits are zero.
    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                    input logic [IDX_W-1:0] idx);
        return {tag, idx, {IDX_LSB{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage for the data cache: one combinational read port,
// one synchronous write port. Only valid and dirty bits are reset.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int NLINES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [LINE_W-1:0] wr_data,
    input  logic              wr_dirty
);

    logic [NLINES-1:0] valid_bits;
    logic [NLINES-1:0] dirty_bits;
    logic [TAG_W-1:0]  tag_mem  [NLINES];
    logic [LINE_W-1:0] data_mem [NLINES];

    // Line status: reset invalidates every line; any write installs a valid line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_bits <= '0;
            dirty_bits <= '0;
        end else if (wr_en) begin
            valid_bits[wr_idx] <= 1'b1;
            dirty_bits[wr_idx] <= wr_dirty;
        end
    end

    // Tag and data payload: contents only matter once the valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_bits[rd_idx];
    assign rd_dirty = dirty_bits[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/dcache.sv
// Write-back, write-allocate, direct-mapped data cache with a 128-bit line memory bus.
// Loads and store-buffer drains are served one at a time; stores win when both are raised.
module dcache
    import dcache_pkg::*;
#(
    parameter int NLINES     = 4,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              dhit,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    state_t state, state_next;

    // Request captured when it is accepted in IDLE.
    logic              req_wr;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [WORD_W-1:0] req_word;
    logic [DATA_W-1:0] req_wdata;
    logic              take_req;

    // Fields of the live request address.
    logic [TAG_W-1:0]  in_tag;
    logic [IDX_W-1:0]  in_idx;
    logic [WORD_W-1:0] in_word;
    logic              unused_addr_bits;

    // Array ports.
    logic [IDX_W-1:0]  arr_rd_idx;
    logic              arr_valid;
    logic              arr_dirty;
    logic [TAG_W-1:0]  arr_tag;
    logic [LINE_W-1:0] arr_data;
    logic              arr_we;
    logic [LINE_W-1:0] arr_wdata;
    logic              arr_wdirty;

    // Memory-side next values.
    logic              mem_req_next;
    logic              mem_we_next;
    logic [ADDR_W-1:0] mem_addr_next;
    logic [LINE_W-1:0] mem_wdata_next;

    // Statistics, visible only through hierarchy.
    logic [CNT_W-1:0]  hit_cnt;
    logic [CNT_W-1:0]  miss_cnt;
    logic              hit_inc;
    logic              miss_inc;

    logic [LINE_W-1:0] merged_line;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign in_tag           = addr[TAG_LSB +: TAG_W];
    assign in_idx           = addr[IDX_LSB +: IDX_W];
    assign in_word          = addr[WORD_LSB +: WORD_W];
    assign unused_addr_bits = ^addr[WORD_LSB-1:0];

    // In IDLE the live address is looked up; afterwards the captured request owns the port.
    assign arr_rd_idx = (state == IDLE) ? in_idx : req_idx;

    dcache_array #(
        .NLINES (NLINES)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (arr_rd_idx),
        .rd_valid (arr_valid),
        .rd_dirty (arr_dirty),
        .rd_tag   (arr_tag),
        .rd_data  (arr_data),
        .wr_en    (arr_we),
        .wr_idx   (req_idx),
        .wr_tag   (req_tag),
        .wr_data  (arr_wdata),
        .wr_dirty (arr_wdirty)
    );

    // Current line with the store word spliced in at the captured word offset.
    always_comb begin
        merged_line = arr_data;
        for (int w = 0; w < LINE_WORDS; w++) begin
            if (int'(req_word) == w) begin
                merged_line[w*DATA_W +: DATA_W] = req_wdata;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, memory request, array write and completion outputs.
    always_comb begin
        state_next     = state;
        mem_req_next   = mem_req;
        mem_we_next    = mem_we;
        mem_addr_next  = mem_addr;
        mem_wdata_next = mem_wdata;
        take_req       = 1'b0;
        arr_we         = 1'b0;
        arr_wdata      = mem_rdata;
        arr_wdirty     = 1'b0;
        hit_inc        = 1'b0;
        miss_inc       = 1'b0;
        dhit           = 1'b0;
        rdata          = '0;

        unique case (state)
            IDLE: begin
                if (wr_req || rd_req) begin
                    take_req = 1'b1;
                    if (arr_valid && (arr_tag == in_tag)) begin
                        hit_inc    = 1'b1;
                        state_next = RESPOND;
                    end else begin
                        miss_inc     = 1'b1;
                        mem_req_next = 1'b1;
                        if (arr_valid && arr_dirty) begin
                            // Evict the dirty victim before fetching the new line.
                            state_next     = WRITEBACK;
                            mem_we_next    = 1'b1;
                            mem_addr_next  = line_addr(arr_tag, in_idx);
                            mem_wdata_next = arr_data;
                        end else begin
                            state_next    = REFILL;
                            mem_we_next   = 1'b0;
                            mem_addr_next = line_addr(in_tag, in_idx);
                        end
                    end
                end
            end
            WRITEBACK: begin
                if (mem_ack) begin
                    // Request drops for one cycle before the refill is issued.
                    state_next   = REFILL;
                    mem_req_next = 1'b0;
                    mem_we_next  = 1'b0;
                end
            end
            REFILL: begin
                if (!mem_req) begin
                    mem_req_next  = 1'b1;
                    mem_we_next   = 1'b0;
                    mem_addr_next = line_addr(req_tag, req_idx);
                end else if (mem_ack) begin
                    arr_we       = 1'b1;
                    arr_wdata    = mem_rdata;
                    arr_wdirty   = 1'b0;
                    mem_req_next = 1'b0;
                    state_next   = RESPOND;
                end
            end
            RESPOND: begin
                dhit       = 1'b1;
                state_next = IDLE;
                if (req_wr) begin
                    arr_we     = 1'b1;
                    arr_wdata  = merged_line;
                    arr_wdirty = 1'b1;
                end else begin
                    rdata = arr_data[int'(req_word)*DATA_W +: DATA_W];
                end
            end
        endcase
    end

    // Memory request registers: held stable for the whole transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_req   <= mem_req_next;
            mem_we    <= mem_we_next;
            mem_addr  <= mem_addr_next;
            mem_wdata <= mem_wdata_next;
        end
    end

    // Request capture; a store takes priority so a pending load waits in IDLE.
    always_ff @(posedge clk) begin
        if (take_req) begin
            req_wr    <= wr_req;
            req_tag   <= in_tag;
            req_idx   <= in_idx;
            req_word  <= in_word;
            req_wdata <= wdata;
        end
    end

    // Saturating hit/miss statistics, counted once per accepted request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit_inc) begin
                hit_cnt <= sat_inc(hit_cnt);
            end
            if (miss_inc) begin
                miss_cnt <= sat_inc(miss_cnt);
            end
        end
    end

endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache: miss/refill, write hit, dirty writeback, store priority,
// reset during refill and ack latencies of 1 and 20 cycles.
module tb_dcache;

    logic         clk = 1'b0;
    logic         reset;
    logic         rd_req;
    logic         wr_req;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [31:0]  rdata;
    logic         dhit;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ack;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] LINE_A  = 128'h33333333_22222222_AAAA5555_AAAA5555;
    localparam logic [127:0] WB_A    = 128'h33333333_22222222_12345678_AAAA5555;
    localparam logic [127:0] LINE_B  = 128'h44444444_55555555_CAFEF00D_66666666;
    localparam logic [127:0] LINE_C  = 128'h0C0C0C0C_0B0B0B0B_0A0A0A0A_01010101;
    localparam logic [127:0] LINE_D  = 128'h0D0D0D0D_0E0E0E0E_0F0F0F0F_0BADCAFE;
    localparam logic [127:0] LINE_E  = 128'h77777777_76767676_75757575_74747474;
    localparam logic [127:0] STRAY   = 128'hDEADDEAD_DEADDEAD_DEADDEAD_DEADDEAD;

    always #5 clk = ~clk;

    dcache #(
        .NLINES     (4),
        .LINE_WORDS (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rd_req    (rd_req),
        .wr_req    (wr_req),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .dhit      (dhit),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Hold the ack for lat-1 cycles after the request is seen, then pulse it once.
    task automatic serve(input string tag, input int lat, input logic [127:0] data);
        logic bad;
        bad = 1'b0;
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            if (dhit || !mem_req) bad = 1'b1;
        end
        check({tag, "_held_no_dhit"}, 128'(bad), 128'd0);
        mem_ack   = 1'b1;
        mem_rdata = data;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = '0;
    endtask

    // Request already driven at the current negedge. kind: 0 hit, 1 clean miss, 2 dirty miss.
    task automatic complete(input string name, input logic is_wr, input logic [31:0] a,
                            input int kind, input logic [31:0] wb_addr, input logic [127:0] wb_data,
                            input int wb_lat, input logic [127:0] fill, input int fill_lat,
                            input logic [31:0] exp_rd);
        logic [31:0] fill_addr;
        fill_addr = {a[31:4], 4'h0};
        @(negedge clk);
        if (kind == 2) begin
            check({name, "_wb_req"},  128'(mem_req),   128'd1);
            check({name, "_wb_we"},   128'(mem_we),    128'd1);
            check({name, "_wb_addr"}, 128'(mem_addr),  128'(wb_addr));
            check({name, "_wb_data"}, mem_wdata,       wb_data);
            serve({name, "_wb"}, wb_lat, '0);
            check({name, "_wb_drop"}, 128'(mem_req),   128'd0);
            for (int i = 0; i < 4 && !mem_req; i++) @(negedge clk);
        end
        if (kind != 0) begin
            check({name, "_rf_req"},  128'(mem_req),  128'd1);
            check({name, "_rf_we"},   128'(mem_we),   128'd0);
            check({name, "_rf_addr"}, 128'(mem_addr), 128'(fill_addr));
            serve({name, "_rf"}, fill_lat, fill);
        end
        check({name, "_dhit"},     128'(dhit),    128'd1);
        check({name, "_mem_idle"}, 128'(mem_req), 128'd0);
        if (!is_wr) check({name, "_rdata"}, 128'(rdata), 128'(exp_rd));
    endtask

    // One cycle after completion: dhit must be gone and rdata back to zero.
    task automatic after_dhit(input string name);
        @(negedge clk);
        check({name, "_pulse_end"}, 128'(dhit),  128'd0);
        check({name, "_rdata_0"},   128'(rdata), 128'd0);
    endtask

    initial begin
        reset = 1'b1; rd_req = 1'b0; wr_req = 1'b0; addr = '0; wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_dhit",      128'(dhit),         128'd0);
        check("rst_rdata",     128'(rdata),        128'd0);
        check("rst_mem_req",   128'(mem_req),      128'd0);
        check("rst_mem_we",    128'(mem_we),       128'd0);
        check("rst_mem_addr",  128'(mem_addr),     128'd0);
        check("rst_mem_wdata", mem_wdata,          128'd0);
        check("rst_hit_cnt",   128'(dut.hit_cnt),  128'd0);
        check("rst_miss_cnt",  128'(dut.miss_cnt), 128'd0);
        reset = 1'b0;
        @(negedge clk);

        // Cold read miss, ack latency 1.
        rd_req = 1'b1; addr = 32'h0000_0010;
        complete("t1_rd_miss", 1'b0, 32'h0000_0010, 1, '0, '0, 0, LINE_A, 1, 32'hAAAA5555);
        rd_req = 1'b0;
        after_dhit("t1");

        // Write hit then read back the stored word.
        wr_req = 1'b1; addr = 32'h0000_0014; wdata = 32'h1234_5678;
        complete("t2_wr_hit", 1'b1, 32'h0000_0014, 0, '0, '0, 0, '0, 0, '0);
        wr_req = 1'b0;
        after_dhit("t2w");
        rd_req = 1'b1;
        complete("t2_rd_hit", 1'b0, 32'h0000_0014, 0, '0, '0, 0, '0, 0, 32'h1234_5678);
        rd_req = 1'b0;
        after_dhit("t2r");

        // Conflict miss on a dirty line: writeback 0x10, refill 0x50 with 20-cycle ack.
        rd_req = 1'b1; addr = 32'h0000_0054;
        complete("t3_dirty_miss", 1'b0, 32'h0000_0054, 2, 32'h0000_0010, WB_A, 3, LINE_B, 20,
                 32'hCAFE_F00D);
        rd_req = 1'b0;
        after_dhit("t3");

        // Store and load raised together: the store completes first.
        wr_req = 1'b1; rd_req = 1'b1; addr = 32'h0000_0020; wdata = 32'hDEAD_BEEF;
        complete("t4_wr_first", 1'b1, 32'h0000_0020, 1, '0, '0, 0, LINE_C, 1, '0);
        wr_req = 1'b0; addr = 32'h0000_0030;
        after_dhit("t4w");
        complete("t4_rd_second", 1'b0, 32'h0000_0030, 1, '0, '0, 0, LINE_D, 20, 32'h0BAD_CAFE);
        rd_req = 1'b0;
        after_dhit("t4r");
        rd_req = 1'b1; addr = 32'h0000_0020;
        complete("t4_rd_stored", 1'b0, 32'h0000_0020, 0, '0, '0, 0, '0, 0, 32'hDEAD_BEEF);
        rd_req = 1'b0;
        after_dhit("t4s");
        check("cnt_hits",   128'(dut.hit_cnt),  128'd3);
        check("cnt_misses", 128'(dut.miss_cnt), 128'd4);

        // Reset while the refill for 0x74 is outstanding.
        rd_req = 1'b1; addr = 32'h0000_0074;
        @(negedge clk);
        check("t5_rf_req",  128'(mem_req),  128'd1);
        check("t5_rf_addr", 128'(mem_addr), 128'h70);
        @(negedge clk);
        reset = 1'b1; rd_req = 1'b0;
        #1;
        check("t5_rst_mem_req",  128'(mem_req),  128'd0);
        check("t5_rst_mem_addr", 128'(mem_addr), 128'd0);
        check("t5_rst_dhit",     128'(dhit),     128'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = STRAY;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = '0;
        @(negedge clk);
        check("t5_late_ack_req",  128'(mem_req), 128'd0);
        check("t5_late_ack_dhit", 128'(dhit),    128'd0);
        rd_req = 1'b1; addr = 32'h0000_0074;
        complete("t5_remiss", 1'b0, 32'h0000_0074, 1, '0, '0, 0, LINE_E, 2, 32'h7575_7575);
        rd_req = 1'b0;
        after_dhit("t5");
        check("t5_cnt_hits",   128'(dut.hit_cnt),  128'd0);
        check("t5_cnt_misses", 128'(dut.miss_cnt), 128'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dcache.md
DCACHE -- requirements
Module: dcache

Interface
REQ-001 SHALL have parameter NLINES, 4, number of direct-mapped lines (power of 2).
REQ-002 SHALL have parameter LINE_WORDS, 4, 32-bit words per line (fixed at 4; memory bus is 128 bits).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port rd_req  in  1  load request; held with addr stable until dhit.
REQ-006 SHALL have port wr_req  in  1  store request from store buffer drain (sb_write_cache); held with addr/wdata until dhit.
REQ-007 SHALL have port addr  in  32  byte address; [3:2] word, [5:4] index, [31:6] tag; [1:0] ignored.
REQ-008 SHALL have port wdata  in  32  store data.
REQ-009 SHALL have port rdata  out  32  load data, valid in the cycle dhit=1.
REQ-010 SHALL have port dhit  out  1  one-cycle completion pulse for the current request.
REQ-011 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out 32 (line-aligned, [3:0]=0), mem_wdata out 128  memory request, held until mem_ack.
REQ-012 SHALL have ports mem_rdata in 128, mem_ack in 1  memory response; mem_ack is a one-cycle pulse, any latency >=1.

Function
REQ-013 SHALL be write-back, write-allocate, direct-mapped; per line: valid, dirty, 26-bit tag, 128-bit data.
REQ-014 SHALL implement FSM states IDLE, WRITEBACK, REFILL, RESPOND.
REQ-015 SHALL sample requests only in IDLE; requests in other states are ignored until the FSM returns to IDLE.
REQ-016 SHALL, when rd_req and wr_req are both high in IDLE, serve wr_req first; rd_req stays pending.
REQ-017 SHALL on hit (valid and tag match) in IDLE: go to RESPOND; in RESPOND assert dhit=1 for exactly one cycle, then IDLE (hit latency = 1 cycle after request sampled, dhit in cycle 2).
REQ-018 SHALL on a write hit update the addressed word and set dirty in the RESPOND cycle.
REQ-019 SHALL on a read hit drive rdata with the addressed word in the RESPOND cycle; rdata is 0 when dhit=0.
REQ-020 SHALL on miss with victim valid and dirty go to WRITEBACK: mem_req=1, mem_we=1, mem_addr={victim tag, index, 4'b0}, mem_wdata=victim line; on mem_ack go to REFILL.
REQ-021 SHALL on miss with victim invalid or clean go directly to REFILL.
REQ-022 SHALL in REFILL drive mem_req=1, mem_we=0, mem_addr={addr[31:4], 4'b0}; on mem_ack install mem_rdata, tag, valid=1, dirty=0, go to RESPOND; the request then completes as a hit (REQ-017..019).
REQ-023 SHALL drop mem_req in the cycle after mem_ack and never hold mem_req high in IDLE or RESPOND.
REQ-024 SHALL never assert dhit for a request whose miss handling has not completed.
REQ-025 SHALL count hits and misses in two 32-bit saturating counters readable via hierarchy for verification (no ports).

Reset
REQ-026 SHALL on reset=1, asynchronously: FSM to IDLE, all valid and dirty bits 0, dhit=0, rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, counters 0.
REQ-027 SHALL, on reset mid-WRITEBACK or mid-REFILL, abandon the transaction; a mem_ack arriving in IDLE after reset SHALL be ignored.
REQ-028 SHALL not require tag/data arrays to be reset.

Structure
REQ-029 SHALL place FSM state encoding, address field widths (TAG_W=26, IDX_W=2, WORD_W=2) and line width (128) in a shared package dcache_pkg.
REQ-030 SHALL use one sub-module dcache_array (tag/valid/dirty/data storage, one read and one write port, async reset of valid/dirty only).

Verification
REQ-031 SHALL cover: reset, rd_req addr=0x00000010 -> REFILL mem_addr=0x00000010 mem_we=0; ack mem_rdata word1=0xAAAA5555 -> dhit pulse, rdata=0xAAAA5555.
REQ-032 SHALL cover: after REQ-031, wr_req addr=0x00000014 wdata=0x12345678 -> dhit 2 cycles after request, no mem_req; then rd_req same addr -> rdata=0x12345678.
REQ-033 SHALL cover: after REQ-032, rd_req addr=0x00000054 (same index, new tag) -> WRITEBACK mem_addr=0x00000010 with word1=0x12345678, then REFILL mem_addr=0x00000050, then dhit.
REQ-034 SHALL cover: rd_req and wr_req asserted together on different addresses -> write completes first (first dhit), read completes second.
REQ-035 SHALL cover: reset asserted during REFILL before mem_ack -> mem_req=0 immediately; late mem_ack ignored; next access to same addr misses again.
REQ-036 SHALL cover: mem_ack latency 1 and 20 cycles -> identical functional results; dhit exactly one cycle wide in all cases.
